// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared opcode, timing and state definitions for the E-stage multiply/divide unit
//
// Purpose: opcode encodings used by both the E-stage controller and e_mdu,
//          default busy-cycle counts used by the hazard unit, and the MDU
//          state type.
// Ports:   none (package).

package e_mdu_pkg;

  // MDU operation codes as carried on mdu_op
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  // Busy-window lengths; the hazard unit stalls for these plus the start cycle
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit holding architectural HI/LO
//
// Purpose: executes mult/multu/div/divu over a fixed busy window, and
//          mthi/mtlo/mfhi/mflo immediately, against the HI/LO registers.
// Ports:
//   clk      in   clock, all state changes on rising edge
//   reset    in   asynchronous active-low reset
//   start    in   E-stage holds a valid MDU op this cycle
//   mdu_op   in   [3:0] operation code (MDU_* in e_mdu_pkg)
//   rs_val   in   [31:0] dividend / multiplicand / mt source
//   rt_val   in   [31:0] divisor / multiplier
//   busy     out  long operation in flight (registered)
//   hi, lo   out  [31:0] architectural HI/LO
//   mdu_out  out  [31:0] HI for mfhi, LO for mflo, otherwise 0

module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  mdu_state_t  state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        busy_n;
  logic [31:0] hi_n, lo_n;
  logic [31:0] p_hi, p_lo, p_hi_n, p_lo_n;
  // Set when the pending op was a divide by zero: HI/LO must survive completion
  logic        p_keep, p_keep_n;

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated in the start cycle and captured into p_hi/p_lo
  // ---------------------------------------------------------------------------
  logic [63:0]        rs_sx, rt_sx, prod_s, prod_u;
  logic signed [32:0] rs_s33, rt_s33;
  logic [31:0]        rt_nz;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;
  logic               div_zero;

  always_comb begin
    rs_sx    = {{32{rs_val[31]}}, rs_val};
    rt_sx    = {{32{rt_val[31]}}, rt_val};
    prod_s   = $signed(rs_sx) * $signed(rt_sx);
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero = (rt_val == 32'd0);
    // Substitute 1 for a zero divisor so the dividers never see /0;
    // the result is discarded through p_keep anyway.
    rt_nz    = div_zero ? 32'd1 : rt_val;
    // 33-bit signed operands make 0x80000000 / -1 land on +2^31,
    // whose low 32 bits are the required 0x80000000 with remainder 0.
    rs_s33   = $signed({rs_val[31], rs_val});
    rt_s33   = $signed({rt_nz[31], rt_nz});
    quot_s   = 32'(rs_s33 / rt_s33);
    rem_s    = 32'(rs_s33 % rt_s33);
    quot_u   = rs_val / rt_nz;
    rem_u    = rs_val % rt_nz;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MDU_IDLE;
      cnt    <= 4'd0;
      busy   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      p_keep <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy   <= busy_n;
      hi     <= hi_n;
      lo     <= lo_n;
      p_hi   <= p_hi_n;
      p_lo   <= p_lo_n;
      p_keep <= p_keep_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    busy_n   = busy;
    hi_n     = hi;
    lo_n     = lo;
    p_hi_n   = p_hi;
    p_lo_n   = p_lo;
    p_keep_n = p_keep;

    case (state)
      MDU_IDLE: begin
        if (start) begin
          if (is_long_op(mdu_op)) begin
            state_n  = MDU_BUSY;
            busy_n   = 1'b1;
            p_keep_n = 1'b0;
            cnt_n    = 4'(DIV_CYCLES);
          end
          case (mdu_op)
            MDU_MULT: begin
              p_hi_n = prod_s[63:32];
              p_lo_n = prod_s[31:0];
              cnt_n  = 4'(MULT_CYCLES);
            end
            MDU_MULTU: begin
              p_hi_n = prod_u[63:32];
              p_lo_n = prod_u[31:0];
              cnt_n  = 4'(MULT_CYCLES);
            end
            MDU_DIV: begin
              p_hi_n   = rem_s;
              p_lo_n   = quot_s;
              p_keep_n = div_zero;
            end
            MDU_DIVU: begin
              p_hi_n   = rem_u;
              p_lo_n   = quot_u;
              p_keep_n = div_zero;
            end
            MDU_MTHI: hi_n = rs_val;
            MDU_MTLO: lo_n = rs_val;
            default: ;
          endcase
        end
      end

      MDU_BUSY: begin
        // Start here is a stall-logic violation and is deliberately ignored
        if (cnt == 4'd1) begin
          if (!p_keep) begin
            hi_n = p_hi;
            lo_n = p_lo;
          end
          cnt_n   = 4'd0;
          busy_n  = 1'b0;
          state_n = MDU_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end

      default: begin
        state_n = MDU_IDLE;
        busy_n  = 1'b0;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Read port depends only on registers and mdu_op
  always_comb begin
    mdu_out = 32'd0;
    if (mdu_op == MDU_MFHI) mdu_out = hi;
    else if (mdu_op == MDU_MFLO) mdu_out = lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu against an arithmetic reference model

module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo, mdu_out;

  int total = 0;
  int bad   = 0;

  // Reference architectural state
  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mdu_out (mdu_out)
  );

  always #5 clk = ~clk;

  // Stall logic must never let a start through while busy
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      assert (!(start === 1'b1 && busy === 1'b1)) else begin
        bad++;
        $error("FAIL protocol start_while_busy observed=1 expected=0");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MIPS HI/LO semantics from plain integer arithmetic
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (op)
      MDU_MULT: begin
        ps = longint'(sa) * longint'(sb);
        pu = ps;
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      MDU_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      MDU_DIV: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'd0;
          end else begin
            m_lo = sa / sb;
            m_hi = sa % sb;
          end
        end
      end
      MDU_DIVU: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      MDU_MTHI: m_hi = a;
      MDU_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue a long op; count busy cycles (bounded) and check the result
  task automatic run_long(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    int n;
    int expn;
    logic [31:0] old_hi;
    expn   = (op == MDU_MULT || op == MDU_MULTU) ? NM : ND;
    old_hi = m_hi;
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE; rs_val = $urandom; rt_val = $urandom;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == expn) chk({tag, "_hi_held"}, hi, old_hi);
      @(negedge clk);
    end
    model_op(op, a, b);
    chk({tag, "_busy_cycles"}, 32'(n), 32'(expn));
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  task automatic run_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE;
    model_op(op, a, 32'd0);
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  task automatic run_mf(input string tag, input logic [3:0] op);
    @(negedge clk);
    start = 1'b1; mdu_op = op;
    #1;
    chk({tag, "_out"}, mdu_out, (op == MDU_MFHI) ? m_hi : m_lo);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          pick;

    reset = 1'b0; start = 1'b0; mdu_op = MDU_MFLO; rs_val = 0; rt_val = 0;
    m_hi = 0; m_lo = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_mflo", mdu_out, 32'd0);
    reset = 1'b1;
    mdu_op = MDU_NONE;

    run_mf("mflo_after_reset", MDU_MFLO);

    run_long("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", lo, 32'hFFFF_FFF1);

    run_long("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_const", hi, 32'h0000_0001);
    chk("multu_lo_const", lo, 32'hFFFF_FFFE);

    run_long("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi_const", hi, 32'hFFFF_FFFF);

    run_long("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", lo, 32'h8000_0000);
    chk("div_ovf_hi_const", hi, 32'd0);

    run_mt("mthi_11", MDU_MTHI, 32'h11);
    run_mt("mtlo_22", MDU_MTLO, 32'h22);
    run_long("divu_zero", MDU_DIVU, 32'h1234_5678, 32'd0);
    chk("divu_zero_hi_const", hi, 32'h11);
    chk("divu_zero_lo_const", lo, 32'h22);
    run_long("div_zero", MDU_DIV, 32'h8765_4321, 32'd0);

    run_mt("mthi_dead", MDU_MTHI, 32'hDEAD_BEEF);
    run_mf("mfhi_dead", MDU_MFHI);
    chk("mfhi_dead_const", hi, 32'hDEAD_BEEF);

    @(negedge clk);
    mdu_op = MDU_MTHI;
    #1 chk("mdu_out_non_mf", mdu_out, 32'd0);
    mdu_op = MDU_NONE;

    // Reset during the third busy cycle of a multiply
    run_mt("mtlo_pre", MDU_MTLO, 32'h55);
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; rs_val = 32'd7; rt_val = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    m_hi = 0; m_lo = 0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_late_commit_lo", lo, 32'd0);
    run_long("div_after_rst", MDU_DIV, 32'd100, 32'd7);

    // Randomized mix against the reference model
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: op = MDU_MULT;
        1: op = MDU_MULTU;
        2: op = MDU_DIV;
        3: op = MDU_DIVU;
        4: op = MDU_MTHI;
        default: op = MDU_MTLO;
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 17);
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if (op == MDU_MTHI || op == MDU_MTLO) run_mt($sformatf("rnd%0d_mt", i), op, a);
      else run_long($sformatf("rnd%0d_op%0d", i, op), op, a, b);
      run_mf($sformatf("rnd%0d_mf", i), ($urandom_range(0, 1) == 1) ? MDU_MFHI : MDU_MFLO);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
